// File: rtl/object_draw_fsm.sv
// object_draw_fsm: pixel writer between game-object logic and the VGA adapter.
// On each accepted move request it erases the previously drawn rectangle in
// BG_COLOR, then draws the object at the new position. One pixel is emitted per
// clock. Off-screen pixels are suppressed but still take a cycle, so latency is fixed.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   go         single-cycle request, accepted only when idle
//   hide       sampled with go; 1 = erase only, no redraw
//   new_x/y    new top-left position, sampled with go
//   color      object colour, sampled with go
//   vga_x/y    pixel coordinate (registered)
//   vga_color  pixel colour (registered)
//   plot       pixel write strobe (registered)
//   busy       high while pixels are being scanned
//   done       one-cycle completion pulse
module object_draw_fsm #(
  parameter int unsigned   XRES     = 160,
  parameter int unsigned   YRES     = 120,
  parameter int unsigned   XW       = 8,
  parameter int unsigned   YW       = 7,
  parameter int unsigned   CW       = 3,
  parameter int unsigned   OBJ_W    = 4,
  parameter int unsigned   OBJ_H    = 4,
  parameter logic [CW-1:0] BG_COLOR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          hide,
  input  logic [XW-1:0] new_x,
  input  logic [YW-1:0] new_y,
  input  logic [CW-1:0] color,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_color,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  // Wide enough for offsets 0..15 of an object up to 16 pixels.
  localparam int unsigned CNTW = 5;
  localparam logic [CNTW-1:0] DxLast = CNTW'(OBJ_W - 1);
  localparam logic [CNTW-1:0] DyLast = CNTW'(OBJ_H - 1);

  typedef enum logic [1:0] {StIdle, StErase, StDraw, StFin} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [XW-1:0]   lat_x_q, lat_x_d, old_x_q, old_x_d;
  logic [YW-1:0]   lat_y_q, lat_y_d, old_y_q, old_y_d;
  logic [CW-1:0]   lat_c_q, lat_c_d;
  logic            lat_hide_q, lat_hide_d;
  logic            old_valid_q, old_valid_d;

  logic [XW-1:0]   vga_x_d;
  logic [YW-1:0]   vga_y_d;
  logic [CW-1:0]   vga_color_d;
  logic            plot_d, busy_d, done_d;

  logic            scan_last;
  logic [CNTW-1:0] dx_inc, dy_inc;

  assign scan_last = (dx_q == DxLast) && (dy_q == DyLast);
  // Row-major advance: dx wraps to 0 and bumps dy.
  assign dx_inc    = (dx_q == DxLast) ? '0 : dx_q + 1'b1;
  assign dy_inc    = (dx_q == DxLast) ? dy_q + 1'b1 : dy_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      dx_q        <= '0;
      dy_q        <= '0;
      lat_x_q     <= '0;
      lat_y_q     <= '0;
      lat_c_q     <= '0;
      lat_hide_q  <= 1'b0;
      old_valid_q <= 1'b0;
      old_x_q     <= '0;
      old_y_q     <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_color   <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      lat_x_q     <= lat_x_d;
      lat_y_q     <= lat_y_d;
      lat_c_q     <= lat_c_d;
      lat_hide_q  <= lat_hide_d;
      old_valid_q <= old_valid_d;
      old_x_q     <= old_x_d;
      old_y_q     <= old_y_d;
      vga_x       <= vga_x_d;
      vga_y       <= vga_y_d;
      vga_color   <= vga_color_d;
      plot        <= plot_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Next-state logic. dx/dy always name the pixel presented in the state being entered.
  always_comb begin
    state_d     = state_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    lat_x_d     = lat_x_q;
    lat_y_d     = lat_y_q;
    lat_c_d     = lat_c_q;
    lat_hide_d  = lat_hide_q;
    old_valid_d = old_valid_q;
    old_x_d     = old_x_q;
    old_y_d     = old_y_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          lat_x_d    = new_x;
          lat_y_d    = new_y;
          lat_c_d    = color;
          lat_hide_d = hide;
          dx_d       = '0;
          dy_d       = '0;
          if (old_valid_q) state_d = StErase;
          else if (!hide)  state_d = StDraw;
          else             state_d = StFin;
        end
      end
      StErase: begin
        if (scan_last) begin
          dx_d    = '0;
          dy_d    = '0;
          state_d = lat_hide_q ? StFin : StDraw;
        end else begin
          dx_d = dx_inc;
          dy_d = dy_inc;
        end
      end
      StDraw: begin
        if (scan_last) begin
          state_d = StFin;
        end else begin
          dx_d = dx_inc;
          dy_d = dy_inc;
        end
      end
      StFin: begin
        state_d = StIdle;
        if (lat_hide_q) begin
          old_valid_d = 1'b0;
        end else begin
          old_valid_d = 1'b1;
          old_x_d     = lat_x_q;
          old_y_d     = lat_y_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic, computed from the next state so the registered outputs line up with it.
  logic          active;
  logic [XW-1:0] base_x;
  logic [YW-1:0] base_y;
  logic [CW-1:0] base_c;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;

  always_comb begin
    active      = (state_d == StErase) || (state_d == StDraw);
    base_x      = (state_d == StErase) ? old_x_q  : lat_x_d;
    base_y      = (state_d == StErase) ? old_y_q  : lat_y_d;
    base_c      = (state_d == StErase) ? BG_COLOR : lat_c_d;
    // One bit wider so positions past the right/bottom edge do not wrap back on screen.
    sum_x       = {1'b0, base_x} + (XW + 1)'(dx_d);
    sum_y       = {1'b0, base_y} + (YW + 1)'(dy_d);
    plot_d      = active && (sum_x < (XW + 1)'(XRES)) && (sum_y < (YW + 1)'(YRES));
    busy_d      = active;
    done_d      = (state_d == StFin);
    vga_x_d     = active ? sum_x[XW-1:0] : '0;
    vga_y_d     = active ? sum_y[YW-1:0] : '0;
    vga_color_d = active ? base_c : '0;
  end

endmodule

// File: tb/tb_object_draw_fsm.sv
module tb_object_draw_fsm;

  logic       clk = 1'b0;
  logic       reset, go, hide;
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [2:0] color;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_color;
  logic       plot, busy, done;

  object_draw_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .hide     (hide),
    .new_x    (new_x),
    .new_y    (new_y),
    .color    (color),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .vga_color(vga_color),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what is on screen right now.
  bit model_valid = 1'b0;
  int model_ox = 0;
  int model_oy = 0;

  typedef struct {
    bit plot;
    int x;
    int y;
    int c;
  } pix_t;

  typedef struct {
    bit h;
    int x;
    int y;
    int c;
    int glitch;   // cycle at which a stray go is pulsed (0 = none)
    int rst_at;   // cycle at which reset is asserted (0 = none)
    int lat;      // expected done cycle (-1 = not checked)
    int plots;    // expected number of plot pulses (-1 = not checked)
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_rect(inout pix_t q[$], input int x0, input int y0, input int c);
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        pix_t p;
        p.x = x0 + dx;
        p.y = y0 + dy;
        p.c = c;
        p.plot = (p.x < 160) && (p.y < 120);
        q.push_back(p);
      end
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    pix_t exp_q[$];
    int   lat, cyc, done_at, plots;
    pix_t ep;
    if (model_valid) add_rect(exp_q, model_ox, model_oy, 0);
    if (!v.h) add_rect(exp_q, v.x, v.y, v.c);
    lat = exp_q.size() + 1;

    @(negedge clk);
    go    = 1'b1;
    hide  = v.h;
    new_x = 8'(v.x);
    new_y = 7'(v.y);
    color = 3'(v.c);
    @(posedge clk);
    #1;
    go      = 1'b0;
    cyc     = 1;
    done_at = -1;
    plots   = 0;
    while (cyc <= 200) begin
      if (cyc == v.rst_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check({tag, "_rst_plot"}, int'(plot), 0);
        check({tag, "_rst_busy"}, int'(busy), 0);
        check({tag, "_rst_done"}, int'(done), 0);
        check({tag, "_rst_x"}, int'(vga_x), 0);
        model_valid = 1'b0;
        return;
      end
      if (cyc <= exp_q.size()) ep = exp_q[cyc-1];
      else ep = '{plot: 1'b0, x: 0, y: 0, c: 0};
      check({tag, "_plot"}, int'(plot), int'(ep.plot));
      if (ep.plot) begin
        check({tag, "_x"}, int'(vga_x), ep.x);
        check({tag, "_y"}, int'(vga_y), ep.y);
        check({tag, "_color"}, int'(vga_color), ep.c);
      end
      check({tag, "_busy"}, int'(busy), int'(cyc <= exp_q.size()));
      check({tag, "_done"}, int'(done), int'(cyc == lat));
      if (plot) plots++;
      if (done) begin
        done_at = cyc;
        break;
      end
      if (cyc == v.glitch) begin
        go    = 1'b1;
        hide  = 1'b1;
        new_x = 8'(v.x + 7);
        new_y = 7'(v.y + 3);
        color = 3'(v.c + 1);
      end else if (cyc == v.glitch + 1) begin
        go = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    go = 1'b0;
    if (done_at < 0) check({tag, "_done_timeout"}, 0, 1);
    else check({tag, "_latency_model"}, done_at, lat);
    if (v.lat >= 0) check({tag, "_latency"}, done_at, v.lat);
    if (v.plots >= 0) check({tag, "_nplots"}, plots, v.plots);

    if (v.h) model_valid = 1'b0;
    else begin
      model_valid = 1'b1;
      model_ox    = v.x;
      model_oy    = v.y;
    end
    // Let the block return to idle before the next request.
    @(posedge clk);
    #1;
    check({tag, "_post_done"}, int'(done), 0);
    check({tag, "_post_plot"}, int'(plot), 0);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b0,  10,  20, 4, 0, 0, 17, 16};
    tbl[1]  = '{1'b0,  11,  20, 2, 0, 0, 33, 32};
    tbl[2]  = '{1'b0, 158, 118, 5, 0, 0, 33, 20};
    tbl[3]  = '{1'b0, 158, 118, 6, 0, 0, 33,  8};
    tbl[4]  = '{1'b0,  30,  40, 3, 5, 0, 33, 20};
    tbl[5]  = '{1'b1,  99,  99, 7, 0, 0, 17, 16};
    tbl[6]  = '{1'b0,  50,  60, 6, 0, 0, 17, 16};
    tbl[7]  = '{1'b1,   0,   0, 0, 0, 0, 17, 16};
    tbl[8]  = '{1'b0,  70,  80, 1, 0, 8, -1, -1};
    tbl[9]  = '{1'b1,   5,   5, 5, 0, 0,  1,  0};
    tbl[10] = '{1'b0,  90, 100, 7, 0, 0, 17, 16};

    reset = 1'b1;
    go    = 1'b0;
    hide  = 1'b0;
    new_x = '0;
    new_y = '0;
    color = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_plot", int'(plot), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_x", int'(vga_x), 0);
    check("reset_y", int'(vga_y), 0);
    check("reset_color", int'(vga_color), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 25; i++) begin
      vec_t v;
      v.h      = ($urandom_range(0, 3) == 0);
      v.x      = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom_range(150, 170);
      v.y      = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 127) : $urandom_range(112, 127);
      v.c      = $urandom_range(0, 7);
      v.glitch = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : 0;
      v.rst_at = 0;
      v.lat    = -1;
      v.plots  = -1;
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/object_draw_fsm.md
Name: object_draw_fsm

Overview:
- Pixel-writer stage that sits between the game-object logic inside vga_demo and the VGA adapter's pixel-write port.
- On each move request it erases the object's previous rectangle by painting it in the background colour, then draws the object at its new position.
- It emits one pixel per clock as plot/x/y/colour and clips any pixel that falls off the screen.
- It tracks the last drawn position itself, so callers only supply the new position.

Parameters:
- XRES, 160, screen width in pixels
- YRES, 120, screen height in pixels
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- CW, 3, colour width
- OBJ_W, 4, object width in pixels (1..16)
- OBJ_H, 4, object height in pixels (1..16)
- BG_COLOR, 3'b000, erase colour

Ports:
- Clock  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high reset
- go  in  1  single-cycle request; sampled only in IDLE
- hide  in  1  sampled with go; 1 = erase only, no redraw
- new_x  in  XW  new top-left x, sampled with go
- new_y  in  YW  new top-left y, sampled with go
- color  in  CW  object colour, sampled with go
- vga_x  out  XW  pixel x
- vga_y  out  YW  pixel y
- vga_color  out  CW  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high from the cycle after an accepted go through the last pixel cycle
- done  out  1  one-cycle pulse when the operation completes

Behaviour:
- Reset is synchronous and active-high, and is honoured in every state, including mid-operation. Reset forces:
  - state = IDLE
  - plot = busy = done = 0
  - vga_x = vga_y = vga_color = 0
  - old_valid = 0, old_x = old_y = 0
  - No stale pixel is emitted after reset.
- All outputs are registered.
- States:
  - IDLE: on go=1, latch new_x, new_y, color and hide. If old_valid=1, go to ERASE; else if hide=0, go to DRAW; else go to FIN. go while busy is ignored and not queued.
  - ERASE: scan dy = 0..OBJ_H-1 (outer) and dx = 0..OBJ_W-1 (inner) from (old_x, old_y), one pixel per cycle, vga_color = BG_COLOR. After the last pixel: go to DRAW if hide=0, else go to FIN.
  - DRAW: same scan from the latched new position with the latched colour. After the last pixel go to FIN.
  - FIN: done = 1 for one cycle, busy = 0. If the operation drew, set old_x/old_y = latched position and old_valid = 1; if hide=1, clear old_valid. Then go to IDLE.
- Latency:
  - Pixel outputs start the cycle after go.
  - done asserts exactly N cycles after go, where N = (erase ? OBJ_W*OBJ_H : 0) + (draw ? OBJ_W*OBJ_H : 0) + 1.
- Clipping:
  - Sums x+dx and y+dy are computed one bit wider than XW/YW.
  - If x+dx ≥ XRES or y+dy ≥ YRES, plot = 0 for that cycle, but the cycle is still consumed, so latency stays fixed.
  - vga_x/vga_y then carry the truncated value; it is don't-care.
- plot = 0 in IDLE and FIN.
- Counters dx and dy reset to 0 on entry to ERASE and to DRAW.
- go with hide=1 while old_valid=0 goes straight to FIN: done pulses 1 cycle after go and no pixels are emitted.

Test Plan:
1. Reset, then go with (10,20), color 3'b100, hide=0 → 16 plot pulses at cycles 1..16 covering x 10..13, y 20..23 in row-major order with colour 100; done at cycle 17; busy high for cycles 1..16.
2. Then go with (11,20), color 3'b010 → 16 BG pixels at (10..13, 20..23), then 16 pixels of colour 010 at (11..14, 20..23); done 33 cycles after go.
3. Object at (158,118), go to (158,118) → pixels with x ≥ 160 or y ≥ 120 have plot=0; exactly 4 of the 16 draw pixels are plotted; done still lands at the fixed cycle.
4. go pulsed again at cycle 5 of an active draw → ignored: no extra pixels, done timing unchanged, latched position unchanged.
5. go with hide=1 on a visible object → 16 BG pixels, done at cycle 17, old_valid cleared. A following go with hide=0 draws only: done at cycle 17.
6. Reset asserted at cycle 8 of a DRAW → next cycle plot=0, busy=0, done=0. The next go performs no erase.
